addsub_pipe: RTL and testbench

//   Parametrised, pipelined signed/unsigned adder-subtractor with valid/ready handshake.

---
 rtl/addsub_pipe.sv | 190 +++++++++++++++++++
 tb/tb_addsub_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// addsub_pipe
//   Pipelined signed/unsigned adder-subtractor with a valid/ready handshake.
//   The WIDTH-bit carry chain is cut into STAGES registered slices of
//   SLICE = WIDTH/STAGES bits. Stage k adds slice k of A and B' with the
//   carry registered by stage k-1. Operand slices that are not yet summed
//   travel alongside, skewed by one register per stage. Finished sum slices
//   travel the same way. One result per clock; latency STAGES cycles.
//
// Parameters
//   WIDTH   operand/result width (>= 2)
//   STAGES  number of pipeline slices (must divide WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle (combinational from out_ready)
//   in_a       operand A
//   in_b       operand B
//   in_cin     carry-in (add) / borrow-in (sub)
//   in_sub     0: A+B+cin, 1: A-B-borrow
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_s      result (modulo 2^WIDTH, or saturated, see below)
//   out_cout   carry out of the MSB (for subtraction: 1 = no borrow)
//   out_ovfl   signed overflow (carry into MSB xor carry out of MSB)
//   out_zero   out_s == 0
//
// Build option
//   ADDSUB_SAT_EN  when defined, a signed overflow saturates out_s to the
//                  signed max (positive operands) or signed min (negative
//                  operands). out_ovfl still reports the overflow.
// ---------------------------------------------------------------------------
module addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic             out_ovfl,
    output logic             out_zero
);

    localparam int SLICE = WIDTH / STAGES;

    // Global advance: the whole pipe moves together or holds together.
    logic adv;

    // Inter-stage buses. Index 0 is the input side; index k+1 is the
    // register output of stage k.
    //   st_s : summed slices below the current one, raw A slices above it
    //   st_b : effective B' slices still waiting to be summed (summed ones
    //          are cleared to zero)
    //   st_c : carry into the next slice
    //   st_v : beat valid
    logic [WIDTH-1:0] st_s [STAGES+1];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [STAGES:0]  st_c;
    logic [STAGES:0]  st_v;

    assign out_valid = st_v[STAGES];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // Subtraction as A + ~B + ~borrow; in_sub/in_cin only matter at entry.
    assign st_s[0] = in_a;
    assign st_b[0] = in_sub ? ~in_b : in_b;
    assign st_c[0] = in_sub ^ in_cin;
    assign st_v[0] = in_valid && adv;

    assign out_s    = st_s[STAGES];
    assign out_cout = st_c[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SLICE;

        logic [SLICE:0]   sum_w;
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;

        assign sum_w = {1'b0, st_s[k][LO +: SLICE]}
                     + {1'b0, st_b[k][LO +: SLICE]}
                     + {{SLICE{1'b0}}, st_c[k]};

        if (k == STAGES - 1) begin : g_last
            logic [WIDTH-1:0] wrap_w;
            logic             a_msb;
            logic             b_msb;
            logic             cmsb_in;
            logic             ovfl_d;
            logic             ovfl_q;
            logic             zero_d;
            logic             zero_q;

            always_comb begin
                wrap_w              = st_s[k];
                wrap_w[LO +: SLICE] = sum_w[SLICE-1:0];
            end

            // The final slice holds the MSB; recover the carry into the MSB
            // from its sum bit, then compare it with the slice carry-out.
            assign a_msb   = st_s[k][WIDTH-1];
            assign b_msb   = st_b[k][WIDTH-1];
            assign cmsb_in = sum_w[SLICE-1] ^ a_msb ^ b_msb;
            assign ovfl_d  = cmsb_in ^ sum_w[SLICE];

`ifdef ADDSUB_SAT_EN
            // On overflow A and B' share a sign, so A's MSB picks the rail.
            always_comb begin
                s_d = wrap_w;
                if (ovfl_d) begin
                    s_d = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
`else
            assign s_d = wrap_w;
`endif

            assign zero_d = (s_d == '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovfl_q <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv && st_v[k]) begin
                    ovfl_q <= ovfl_d;
                    zero_q <= zero_d;
                end
            end

            assign out_ovfl = ovfl_q;
            assign out_zero = zero_q;
        end else begin : g_mid
            logic [WIDTH-1:0] b_d;
            logic [WIDTH-1:0] b_q;

            always_comb begin
                s_d              = st_s[k];
                s_d[LO +: SLICE] = sum_w[SLICE-1:0];
                b_d              = st_b[k];
                b_d[LO +: SLICE] = '0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (adv && st_v[k]) begin
                    b_q <= b_d;
                end
            end

            assign st_b[k+1] = b_q;
        end

        // Data registers load only with a valid beat, so the outputs keep
        // their reset value until the first real result arrives.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= st_v[k];
                if (st_v[k]) begin
                    s_q <= s_d;
                    c_q <= sum_w[SLICE];
                end
            end
        end

        assign st_s[k+1] = s_q;
        assign st_c[k+1] = c_q;
        assign st_v[k+1] = v_q;
    end

endmodule

// File: tb/tb_addsub_pipe.sv
module tb_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv8, ir8, ov8, or8, cin8, sub8, co8, of8, z8;
  logic [7:0]  a8, b8, s8;
  logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16, z16;
  logic [15:0] a16, b16, s16;

  addsub_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_cin(cin8), .in_sub(sub8),
    .out_valid(ov8), .out_ready(or8), .out_s(s8),
    .out_cout(co8), .out_ovfl(of8), .out_zero(z8)
  );

  addsub_pipe #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_cin(cin16), .in_sub(sub16),
    .out_valid(ov16), .out_ready(or16), .out_s(s16),
    .out_cout(co16), .out_ovfl(of16), .out_zero(z16)
  );

  int ntests = 0;
  int nfail  = 0;

  task automatic bad(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nfail++;
    $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  typedef struct {
    longint s;
    bit     cout;
    bit     ovfl;
    bit     zero;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  int          npop8 = 0;
  int          nacc8 = 0;
  bit          acc8;
  bit          rdy8_seen;
  logic [7:0]  last_s8;
  logic        last_co8, last_of8, last_z8;
  logic [15:0] last_s16;

  function automatic exp_t model(input int w, input longint a, input longint b,
                                 input bit cin, input bit sub);
    exp_t   r;
    longint m, c, tot, sa, sb, sr;
    m   = longint'(1) << w;
    c   = cin ? 1 : 0;
    tot = sub ? (a - b - c + m) : (a + b + c);
    r.cout = (tot >= m);
    r.s    = tot % m;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    sr = sub ? (sa - sb - c) : (sa + sb + c);
    r.ovfl = (sr >= m / 2) || (sr < -(m / 2));
`ifdef ADDSUB_SAT_EN
    if (r.ovfl) r.s = (sr > 0) ? (m / 2 - 1) : (m / 2);
`endif
    r.zero = (r.s == 0);
    return r;
  endfunction

  task automatic tick();
    exp_t e;
    #1;
    ntests++; if (ir8 !== (!ov8 || or8)) bad("in_ready8", ir8, (!ov8 || or8));
    ntests++; if (ir16 !== (!ov16 || or16)) bad("in_ready16", ir16, (!ov16 || or16));
    rdy8_seen = ir8;
    if (ov8) begin
      ntests++; if (q8.size() == 0) bad("out8_expected", 0, 1);
      if (q8.size() > 0) begin
        e = q8[0];
        ntests++; if (s8 !== e.s[7:0]) bad("s8", s8, e.s[7:0]);
        ntests++; if (co8 !== e.cout) bad("cout8", co8, e.cout);
        ntests++; if (of8 !== e.ovfl) bad("ovfl8", of8, e.ovfl);
        ntests++; if (z8 !== e.zero) bad("zero8", z8, e.zero);
        if (or8) begin
          e = q8.pop_front();
          npop8++;
          last_s8 = s8; last_co8 = co8; last_of8 = of8; last_z8 = z8;
        end
      end
    end
    if (ov16) begin
      ntests++; if (q16.size() == 0) bad("out16_expected", 0, 1);
      if (q16.size() > 0) begin
        e = q16[0];
        ntests++; if (s16 !== e.s[15:0]) bad("s16", s16, e.s[15:0]);
        ntests++; if (co16 !== e.cout) bad("cout16", co16, e.cout);
        ntests++; if (of16 !== e.ovfl) bad("ovfl16", of16, e.ovfl);
        ntests++; if (z16 !== e.zero) bad("zero16", z16, e.zero);
        if (or16) begin
          e = q16.pop_front();
          last_s16 = s16;
        end
      end
    end
    acc8 = iv8 && ir8;
    if (acc8) begin
      q8.push_back(model(8, a8, b8, cin8, sub8));
      nacc8++;
    end
    if (iv16 && ir16) q16.push_back(model(16, a16, b16, cin16, sub16));
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit cin, input bit sub);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; iv8 = 1'b1; or8 = 1'b1;
    tick();
    iv8 = 1'b0;
    ntests++; if (ov8 !== 1'b0) bad("lat8_early", ov8, 0);
    tick();
    ntests++; if (ov8 !== 1'b1) bad("lat8_valid", ov8, 1);
    tick();
    tick();
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input bit cin, input bit sub);
    a16 = a; b16 = b; cin16 = cin; sub16 = sub; iv16 = 1'b1; or16 = 1'b1;
    tick();
    iv16 = 1'b0;
    tick();
    tick();
    ntests++; if (ov16 !== 1'b0) bad("lat16_early", ov16, 0);
    tick();
    ntests++; if (ov16 !== 1'b1) bad("lat16_valid", ov16, 1);
    tick();
    tick();
  endtask

  initial begin
    int i, c, p0;
    rst_n = 1'b0;
    iv8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; or8 = 1;
    iv16 = 0; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0; or16 = 1;
    repeat (2) @(posedge clk);
    #1;
    ntests++; if (ov8 !== 1'b0) bad("rst_valid8", ov8, 0);
    ntests++; if (s8 !== 8'h00) bad("rst_s8", s8, 8'h00);
    ntests++; if (co8 !== 1'b0) bad("rst_cout8", co8, 0);
    ntests++; if (of8 !== 1'b0) bad("rst_ovfl8", of8, 0);
    ntests++; if (z8 !== 1'b0) bad("rst_zero8", z8, 0);
    ntests++; if (ir8 !== 1'b1) bad("rst_ready8", ir8, 1);
    ntests++; if (ov16 !== 1'b0) bad("rst_valid16", ov16, 0);
    ntests++; if (s16 !== 16'h0000) bad("rst_s16", s16, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick();
    ntests++; if (s8 !== 8'h00) bad("idle_s8", s8, 8'h00);
    ntests++; if (z8 !== 1'b0) bad("idle_zero8", z8, 0);

    send8(8'h3C, 8'h05, 1'b0, 1'b0);
    ntests++; if (last_s8 !== 8'h41) bad("t1_s", last_s8, 8'h41);
    ntests++; if (last_co8 !== 1'b0) bad("t1_cout", last_co8, 0);
    ntests++; if (last_of8 !== 1'b0) bad("t1_ovfl", last_of8, 0);
    ntests++; if (last_z8 !== 1'b0) bad("t1_zero", last_z8, 0);
    send8(8'h7F, 8'h01, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    ntests++; if (last_s8 !== 8'h7F) bad("t2a_s", last_s8, 8'h7F);
`else
    ntests++; if (last_s8 !== 8'h80) bad("t2a_s", last_s8, 8'h80);
`endif
    ntests++; if (last_of8 !== 1'b1) bad("t2a_ovfl", last_of8, 1);
    ntests++; if (last_co8 !== 1'b0) bad("t2a_cout", last_co8, 0);
    send8(8'hFF, 8'h01, 1'b0, 1'b0);
    ntests++; if (last_s8 !== 8'h00) bad("t2b_s", last_s8, 8'h00);
    ntests++; if (last_co8 !== 1'b1) bad("t2b_cout", last_co8, 1);
    ntests++; if (last_z8 !== 1'b1) bad("t2b_zero", last_z8, 1);
    ntests++; if (last_of8 !== 1'b0) bad("t2b_ovfl", last_of8, 0);
    send8(8'h10, 8'h20, 1'b0, 1'b1);
    ntests++; if (last_s8 !== 8'hF0) bad("t3a_s", last_s8, 8'hF0);
    ntests++; if (last_co8 !== 1'b0) bad("t3a_cout", last_co8, 0);
    ntests++; if (last_of8 !== 1'b0) bad("t3a_ovfl", last_of8, 0);
    send8(8'h80, 8'h01, 1'b0, 1'b1);
`ifdef ADDSUB_SAT_EN
    ntests++; if (last_s8 !== 8'h80) bad("t3b_s", last_s8, 8'h80);
`else
    ntests++; if (last_s8 !== 8'h7F) bad("t3b_s", last_s8, 8'h7F);
`endif
    ntests++; if (last_of8 !== 1'b1) bad("t3b_ovfl", last_of8, 1);
    send8(8'h0F, 8'h01, 1'b0, 1'b0);
    ntests++; if (last_s8 !== 8'h10) bad("t5a_s", last_s8, 8'h10);
    send8(8'h00, 8'h00, 1'b1, 1'b1);
    ntests++; if (last_s8 !== 8'hFF) bad("borrow_s", last_s8, 8'hFF);
    send16(16'h00FF, 16'h0001, 1'b0, 1'b0);
    ntests++; if (last_s16 !== 16'h0100) bad("t5b_s", last_s16, 16'h0100);
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    ntests++; if (last_s16 !== 16'h0000) bad("t5c_s", last_s16, 16'h0000);

    i = 0; c = 0; p0 = npop8;
    while ((i < 8 || q8.size() > 0) && c < 40) begin
      iv8 = (i < 8); a8 = 8'(i); b8 = 8'(i); cin8 = 0; sub8 = 0;
      or8 = !(c >= 3 && c <= 5);
      tick();
      ntests++;
      if (rdy8_seen !== !(c >= 3 && c <= 5)) bad("stall_ready", rdy8_seen, !(c >= 3 && c <= 5));
      if (acc8) i++;
      c++;
    end
    iv8 = 0; or8 = 1;
    ntests++; if (i != 8) bad("stream_accepted", i, 8);
    ntests++; if (npop8 - p0 != 8) bad("stream_popped", npop8 - p0, 8);
    ntests++; if (last_s8 !== 8'h0E) bad("stream_last", last_s8, 8'h0E);

    for (int unsigned n = 0; n < 300; n++) begin
      iv8   = ($urandom_range(0, 3) != 0);
      a8    = 8'($urandom_range(0, 255));
      b8    = 8'($urandom_range(0, 255));
      cin8  = 1'($urandom_range(0, 1));
      sub8  = 1'($urandom_range(0, 1));
      or8   = ($urandom_range(0, 3) != 0);
      iv16  = ($urandom_range(0, 3) != 0);
      a16   = 16'($urandom_range(0, 65535));
      b16   = 16'($urandom_range(0, 65535));
      cin16 = 1'($urandom_range(0, 1));
      sub16 = 1'($urandom_range(0, 1));
      or16  = ($urandom_range(0, 3) != 0);
      tick();
    end
    iv8 = 0; or8 = 1; iv16 = 0; or16 = 1;
    for (int unsigned n = 0; n < 8; n++) tick();
    ntests++; if (q8.size() != 0) bad("drain8", q8.size(), 0);
    ntests++; if (q16.size() != 0) bad("drain16", q16.size(), 0);

    iv8 = 1; a8 = 8'h11; b8 = 8'h22; cin8 = 0; sub8 = 0;
    tick();
    a8 = 8'h33;
    tick();
    iv8 = 0;
    rst_n = 1'b0;
    #1;
    ntests++; if (ov8 !== 1'b0) bad("mid_rst_valid", ov8, 0);
    ntests++; if (s8 !== 8'h00) bad("mid_rst_s", s8, 8'h00);
    ntests++; if (co8 !== 1'b0) bad("mid_rst_cout", co8, 0);
    ntests++; if (of8 !== 1'b0) bad("mid_rst_ovfl", of8, 0);
    ntests++; if (z8 !== 1'b0) bad("mid_rst_zero", z8, 0);
    ntests++; if (ir8 !== 1'b1) bad("mid_rst_ready", ir8, 1);
    q8.delete();
    q16.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int unsigned n = 0; n < 4; n++) begin
      tick();
      ntests++; if (ov8 !== 1'b0) bad("post_rst_quiet", ov8, 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
